// File: rtl/frame_buffer_sequencer_pkg.sv
// Shared definitions for the frame buffer sequencer: FSM encoding and default frame geometry.
package frame_buffer_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_WRITE  = 2'd1,
    ST_READ   = 2'd2
  } seq_state_t;

  localparam int FBS_COLUMNS     = 640;
  localparam int FBS_ROWS        = 4;
  localparam int FBS_FRAME_ROWS  = 480;
  localparam int FBS_PIXEL_DEPTH = 3;

  // A window centre trails the write position by one row and one column.
  localparam int FBS_WINDOW_LAG  = 2;

endpackage

// File: rtl/frame_buffer_sequencer_raster_position_counter.sv
// Raster column / frame-row / row-slot counters with wrap, plus interior-window and last-pixel flags.
// Latency: advances one position per cycle with advance=1. Backpressure: none, the caller gates advance.
module raster_position_counter
  import frame_buffer_sequencer_pkg::*;
#(
  parameter int P_COLUMNS         = FBS_COLUMNS,
  parameter int P_ROWS            = FBS_ROWS,
  parameter int P_FRAME_ROWS      = FBS_FRAME_ROWS,
  parameter int P_COLUMNS_BITS    = $clog2(P_COLUMNS),
  parameter int P_ROWS_BITS       = $clog2(P_ROWS),
  parameter int P_FRAME_ROWS_BITS = $clog2(P_FRAME_ROWS)
) (
  input  logic                         I_CLK,
  input  logic                         I_RESET,
  input  logic                         advance,
  output logic [P_COLUMNS_BITS-1:0]    column,
  output logic [P_ROWS_BITS-1:0]       row_slot,
  output logic [P_FRAME_ROWS_BITS-1:0] frame_row,
  output logic                         interior,
  output logic                         frame_last
);

  localparam logic [P_COLUMNS_BITS-1:0]    LAST_COL  = P_COLUMNS_BITS'(P_COLUMNS - 1);
  localparam logic [P_ROWS_BITS-1:0]       LAST_SLOT = P_ROWS_BITS'(P_ROWS - 1);
  localparam logic [P_FRAME_ROWS_BITS-1:0] LAST_ROW  = P_FRAME_ROWS_BITS'(P_FRAME_ROWS - 1);
  localparam logic [P_COLUMNS_BITS-1:0]    LAG_COL   = P_COLUMNS_BITS'(FBS_WINDOW_LAG);
  localparam logic [P_FRAME_ROWS_BITS-1:0] LAG_ROW   = P_FRAME_ROWS_BITS'(FBS_WINDOW_LAG);

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      column    <= '0;
      row_slot  <= '0;
      frame_row <= '0;
    end else if (advance) begin
      if (column == LAST_COL) begin
        column <= '0;
        // Frame end restarts the ring at slot 0 so every frame has the same slot mapping.
        if (frame_row == LAST_ROW) begin
          frame_row <= '0;
          row_slot  <= '0;
        end else begin
          frame_row <= frame_row + 1'b1;
          row_slot  <= (row_slot == LAST_SLOT) ? '0 : row_slot + 1'b1;
        end
      end else begin
        column <= column + 1'b1;
      end
    end
  end

  assign interior   = (frame_row >= LAG_ROW) && (column >= LAG_COL);
  assign frame_last = (frame_row == LAST_ROW) && (column == LAST_COL);

endmodule

// File: rtl/frame_buffer_sequencer.sv
// Raster write/read sequencer for the 3x3 row-ring buffer; FRAME_BUFFER_SEQUENCER_COORD_EN adds window-centre ports.
// Latency: handshake edge k -> write k+1 -> read k+2 -> O_MATRIX_VALID k+3; ready only in ACCEPT (2-3 cycles/pixel).
module frame_buffer_sequencer
  import frame_buffer_sequencer_pkg::*;
#(
  parameter int P_COLUMNS         = FBS_COLUMNS,
  parameter int P_ROWS            = FBS_ROWS,
  parameter int P_FRAME_ROWS      = FBS_FRAME_ROWS,
  parameter int P_PIXEL_DEPTH     = FBS_PIXEL_DEPTH,
  parameter int P_COLUMNS_BITS    = $clog2(P_COLUMNS),
  parameter int P_ROWS_BITS       = $clog2(P_ROWS),
  parameter int P_FRAME_ROWS_BITS = $clog2(P_FRAME_ROWS)
) (
  input  logic                         I_CLK,
  input  logic                         I_RESET,
  input  logic                         I_PIXEL_VALID,
  input  logic [P_PIXEL_DEPTH-1:0]     I_PIXEL,
  output logic                         O_PIXEL_READY,
  output logic [P_COLUMNS_BITS-1:0]    O_COLUMN,
  output logic [P_ROWS_BITS-1:0]       O_ROW,
  output logic [P_PIXEL_DEPTH-1:0]     O_PIXEL,
  output logic                         O_WRITE_ENABLE,
  output logic                         O_READ_ENABLE,
  output logic                         O_MATRIX_VALID,
`ifdef FRAME_BUFFER_SEQUENCER_COORD_EN
  output logic                         O_FRAME_DONE,
  output logic [P_FRAME_ROWS_BITS-1:0] O_MATRIX_ROW,
  output logic [P_COLUMNS_BITS-1:0]    O_MATRIX_COLUMN
`else
  output logic                         O_FRAME_DONE
`endif
);

  localparam logic [P_COLUMNS_BITS-1:0]    LAST_COL  = P_COLUMNS_BITS'(P_COLUMNS - 1);
  localparam logic [P_ROWS_BITS-1:0]       LAST_SLOT = P_ROWS_BITS'(P_ROWS - 1);
  localparam logic [P_FRAME_ROWS_BITS-1:0] LAST_ROW  = P_FRAME_ROWS_BITS'(P_FRAME_ROWS - 1);

  seq_state_t                   state, state_nxt;
  logic [P_PIXEL_DEPTH-1:0]     cap_pixel;
  logic [P_COLUMNS_BITS-1:0]    cap_c, pos_c;
  logic [P_ROWS_BITS-1:0]       cap_s, pos_s;
  logic [P_FRAME_ROWS_BITS-1:0] cap_r, pos_r;
  logic                         pos_interior, pos_last;
  logic                         accept;

  raster_position_counter #(
    .P_COLUMNS        (P_COLUMNS),
    .P_ROWS           (P_ROWS),
    .P_FRAME_ROWS     (P_FRAME_ROWS),
    .P_COLUMNS_BITS   (P_COLUMNS_BITS),
    .P_ROWS_BITS      (P_ROWS_BITS),
    .P_FRAME_ROWS_BITS(P_FRAME_ROWS_BITS)
  ) u_position (
    .I_CLK     (I_CLK),
    .I_RESET   (I_RESET),
    .advance   (state == ST_WRITE),
    .column    (pos_c),
    .row_slot  (pos_s),
    .frame_row (pos_r),
    .interior  (pos_interior),
    .frame_last(pos_last)
  );

  assign accept = (state == ST_ACCEPT) && I_PIXEL_VALID;

  always_comb begin
    state_nxt      = state;
    O_PIXEL_READY  = 1'b0;
    O_WRITE_ENABLE = 1'b0;
    O_READ_ENABLE  = 1'b0;
    O_ROW          = '0;
    O_COLUMN       = '0;
    O_PIXEL        = '0;
    case (state)
      ST_ACCEPT: begin
        O_PIXEL_READY = 1'b1;
        if (I_PIXEL_VALID) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        O_WRITE_ENABLE = 1'b1;
        O_ROW          = cap_s;
        O_COLUMN       = cap_c;
        O_PIXEL        = cap_pixel;
        state_nxt      = pos_interior ? ST_READ : ST_ACCEPT;
      end
      ST_READ: begin
        // Counters have already moved on, so the read uses the captured position.
        O_READ_ENABLE = 1'b1;
        O_ROW         = (cap_s == '0) ? LAST_SLOT : cap_s - 1'b1;
        O_COLUMN      = cap_c - 1'b1;
        state_nxt     = ST_ACCEPT;
      end
      default: state_nxt = ST_ACCEPT;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state          <= ST_ACCEPT;
      cap_pixel      <= '0;
      cap_c          <= '0;
      cap_s          <= '0;
      cap_r          <= '0;
      O_MATRIX_VALID <= 1'b0;
      O_FRAME_DONE   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cap_pixel <= I_PIXEL;
        cap_c     <= pos_c;
        cap_s     <= pos_s;
        cap_r     <= pos_r;
      end
      O_MATRIX_VALID <= (state == ST_READ);
      O_FRAME_DONE   <= (state == ST_READ) && (cap_r == LAST_ROW) && (cap_c == LAST_COL);
    end
  end

`ifdef FRAME_BUFFER_SEQUENCER_COORD_EN
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      O_MATRIX_ROW    <= '0;
      O_MATRIX_COLUMN <= '0;
    end else if (state == ST_READ) begin
      O_MATRIX_ROW    <= cap_r - 1'b1;
      O_MATRIX_COLUMN <= cap_c - 1'b1;
    end
  end
`endif

  logic unused_last;
  assign unused_last = pos_last;

endmodule

// File: tb/tb_frame_buffer_sequencer.sv
// Scoreboard bench for frame_buffer_sequencer on a 4x4 frame with a 4-slot ring.
`timescale 1ns/1ps
module tb_frame_buffer_sequencer;

  localparam int COLS  = 4;
  localparam int ROWS  = 4;
  localparam int FROWS = 4;
  localparam int PD    = 3;
  localparam int CB    = $clog2(COLS);
  localparam int RB    = $clog2(ROWS);
  localparam int FB    = $clog2(FROWS);
  localparam int NPIX  = COLS * FROWS;

  typedef struct {
    int cyc;
    int row;
    int col;
    int val;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vld = 1'b0;
  logic [PD-1:0] pix = '0;
  logic          rdy, we, re, mv, fd;
  logic [CB-1:0] o_col;
  logic [RB-1:0] o_row;
  logic [PD-1:0] o_pix;
`ifdef FRAME_BUFFER_SEQUENCER_COORD_EN
  logic [FB-1:0] m_row;
  logic [CB-1:0] m_col;
`endif

  always #5 clk = ~clk;

  frame_buffer_sequencer #(
    .P_COLUMNS    (COLS),
    .P_ROWS       (ROWS),
    .P_FRAME_ROWS (FROWS),
    .P_PIXEL_DEPTH(PD)
  ) dut (
    .I_CLK          (clk),
    .I_RESET        (rst),
    .I_PIXEL_VALID  (vld),
    .I_PIXEL        (pix),
    .O_PIXEL_READY  (rdy),
    .O_COLUMN       (o_col),
    .O_ROW          (o_row),
    .O_PIXEL        (o_pix),
    .O_WRITE_ENABLE (we),
    .O_READ_ENABLE  (re),
    .O_MATRIX_VALID (mv),
`ifdef FRAME_BUFFER_SEQUENCER_COORD_EN
    .O_FRAME_DONE   (fd),
    .O_MATRIX_ROW   (m_row),
    .O_MATRIX_COLUMN(m_col)
`else
    .O_FRAME_DONE   (fd)
`endif
  );

  int  checks = 0;
  int  passed = 0;
  int  cyc = 0;
  int  n_pos = 0;
  int  mv_cnt = 0;
  int  fd_cnt = 0;
  bit  mon_en = 1'b0;
  ev_t exp_wr[$];
  ev_t exp_rd[$];
  ev_t exp_win[$];
  ev_t mon_e;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: frame position from a flat pixel index; slots restart every frame.
  task automatic model_accept(input int p);
    int r, c;
    r = n_pos / COLS;
    c = n_pos % COLS;
    exp_wr.push_back('{cyc + 1, r % ROWS, c, p % (1 << PD)});
    if (r >= 2 && c >= 2) begin
      exp_rd.push_back('{cyc + 2, (r - 1) % ROWS, c - 1, 0});
      exp_win.push_back('{cyc + 3, r - 1, c - 1, (n_pos == NPIX - 1) ? 1 : 0});
    end
    n_pos = (n_pos + 1) % NPIX;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("we_re_exclusive", int'(we & re), 0);
      if (fd && !mv) check("frame_done_without_valid", 1, 0);
      if (we) begin
        if (exp_wr.size() == 0) check("unexpected_write", 1, 0);
        else begin
          mon_e = exp_wr.pop_front();
          check("write_cycle", cyc, mon_e.cyc);
          check("write_row", int'(o_row), mon_e.row);
          check("write_col", int'(o_col), mon_e.col);
          check("write_pixel", int'(o_pix), mon_e.val);
        end
      end
      if (re) begin
        if (exp_rd.size() == 0) check("unexpected_read", 1, 0);
        else begin
          mon_e = exp_rd.pop_front();
          check("read_cycle", cyc, mon_e.cyc);
          check("read_row", int'(o_row), mon_e.row);
          check("read_col", int'(o_col), mon_e.col);
        end
      end
      if (mv) begin
        mv_cnt++;
        if (fd) fd_cnt++;
        if (exp_win.size() == 0) check("unexpected_matrix_valid", 1, 0);
        else begin
          mon_e = exp_win.pop_front();
          check("window_cycle", cyc, mon_e.cyc);
          check("window_frame_done", int'(fd), mon_e.val);
`ifdef FRAME_BUFFER_SEQUENCER_COORD_EN
          check("window_centre_row", int'(m_row), mon_e.row);
          check("window_centre_col", int'(m_col), mon_e.col);
`endif
        end
      end
    end
  end

  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    repeat (ncyc) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_wr.delete();
    exp_rd.delete();
    exp_win.delete();
    n_pos = 0;
  endtask

  task automatic send(input int p, input bit hold, input int gap);
    bit got;
    got = 1'b0;
    vld = 1'b1;
    pix = PD'(p);
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      if (rdy) begin
        got = 1'b1;
        model_accept(p);
      end
      @(posedge clk);
      #1;
    end
    if (!got) check("handshake_timeout", 0, 1);
    if (!hold) vld = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 20 && (exp_wr.size() + exp_rd.size() + exp_win.size()) != 0; t++)
      @(posedge clk);
    #1;
    check({tag, "_pending_events"}, exp_wr.size() + exp_rd.size() + exp_win.size(), 0);
  endtask

  initial begin
    do_reset(2);
    mon_en = 1'b1;
    @(negedge clk);
    check("reset_ready", int'(rdy), 1);
    check("reset_we", int'(we), 0);
    check("reset_re", int'(re), 0);
    check("reset_matrix_valid", int'(mv), 0);
    check("reset_frame_done", int'(fd), 0);
    @(posedge clk);
    #1;

    send(5, 1'b0, 0);
    @(posedge clk);
    @(negedge clk);
    check("single_ready_after_write", int'(rdy), 1);
    @(posedge clk);
    #1;
    drain("single");

    do_reset(1);
    mv_cnt = 0;
    fd_cnt = 0;
    for (int i = 0; i < NPIX; i++) send(i, 1'b1, 0);
    vld = 1'b0;
    drain("frame1");
    check("frame1_window_count", mv_cnt, 4);
    check("frame1_frame_done_count", fd_cnt, 1);

    mv_cnt = 0;
    for (int i = 0; i < 2 * NPIX; i++) begin
      bit h;
      h = 1'($urandom_range(0, 1));
      send(int'($urandom_range(0, 7)), h, h ? 0 : int'($urandom_range(0, 2)));
    end
    vld = 1'b0;
    drain("random_frames");
    check("random_frames_window_count", mv_cnt, 8);

    for (int i = 0; i < 6; i++) send(6, 1'b1, 0);
    vld = 1'b0;
    drain("valid_held");

    do_reset(1);
    for (int i = 0; i < 10; i++) send(i + 1, 1'b1, 0);
    send(7, 1'b0, 0);
    @(posedge clk);
    #1;
    check("midframe_in_read", int'(re), 1);
    do_reset(1);
    @(negedge clk);
    check("midframe_matrix_valid", int'(mv), 0);
    check("midframe_frame_done", int'(fd), 0);
    check("midframe_ready", int'(rdy), 1);
`ifdef FRAME_BUFFER_SEQUENCER_COORD_EN
    check("midframe_centre_row", int'(m_row), 0);
    check("midframe_centre_col", int'(m_col), 0);
`endif
    repeat (3) @(posedge clk);
    #1;
    send(3, 1'b0, 0);
    drain("after_midframe_reset");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
